// File: rtl/inst_fetcher_if.sv
// rtl/inst_fetcher_if.sv - fetch stage bus bundle: memory fetch port, redirect and queue side
//
// Purpose: groups every non-clock/reset signal of inst_fetcher.
// Signals:
//   rdy                 global ready; low freezes the fetcher
//   start_query_signal  one-cycle fetch request pulse to the memory controller
//   pc_to_mem           fetch address, valid with start_query_signal
//   finish_query_signal one-cycle completion pulse from the memory controller
//   inst_from_mem       fetched word, valid with finish_query_signal
//   flush_signal        redirect from commit
//   flush_target_pc     redirect PC, valid with flush_signal
//   queue_full_signal   instruction queue has no free slot
//   inst_valid_to_queue one-cycle delivery pulse
//   inst_to_queue       delivered instruction
//   pc_to_queue         PC of the delivered instruction
// Modports: master = fetcher side, slave = environment side.

interface inst_fetcher_if;
   logic        rdy;
   logic        start_query_signal;
   logic [31:0] pc_to_mem;
   logic        finish_query_signal;
   logic [31:0] inst_from_mem;
   logic        flush_signal;
   logic [31:0] flush_target_pc;
   logic        queue_full_signal;
   logic        inst_valid_to_queue;
   logic [31:0] inst_to_queue;
   logic [31:0] pc_to_queue;

   modport master (
      input  rdy,
      input  finish_query_signal,
      input  inst_from_mem,
      input  flush_signal,
      input  flush_target_pc,
      input  queue_full_signal,
      output start_query_signal,
      output pc_to_mem,
      output inst_valid_to_queue,
      output inst_to_queue,
      output pc_to_queue
   );

   modport slave (
      output rdy,
      output finish_query_signal,
      output inst_from_mem,
      output flush_signal,
      output flush_target_pc,
      output queue_full_signal,
      input  start_query_signal,
      input  pc_to_mem,
      input  inst_valid_to_queue,
      input  inst_to_queue,
      input  pc_to_queue
   );
endinterface

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - instruction fetch stage with optional direct-mapped I-cache
//
// Purpose: holds the fetch PC, issues one fetch query per miss, forwards each
// returned word with its PC as a one-cycle pulse, and restarts on flush.
// Optional feature macro: ICACHE_EN (direct-mapped cache of
// 2^ICACHE_INDEX_WIDTH one-word lines; hits deliver without a memory trip).
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  inst_fetcher_if.master (memory fetch port, flush, queue side, rdy)
// Parameters:
//   ICACHE_INDEX_WIDTH  log2 of cache line count (ICACHE_EN only)
//   RESET_PC            fetch PC after reset

module inst_fetcher #(
   parameter int          ICACHE_INDEX_WIDTH = 6,
   parameter logic [31:0] RESET_PC           = 32'h0
) (
   input  logic           clk,
   input  logic           rst,
   inst_fetcher_if.master bus
);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic        start_q, start_n;
   logic [31:0] pc_mem_q, pc_mem_n;
   logic        valid_q, valid_n;
   logic [31:0] inst_q, inst_n;
   logic [31:0] pc_q, pc_q_n;
   logic        fill;
   logic        cache_hit;
   logic [31:0] cache_word;

`ifdef ICACHE_EN
   localparam int LINES = 1 << ICACHE_INDEX_WIDTH;
   localparam int TAG_W = 30 - ICACHE_INDEX_WIDTH;

   logic [LINES-1:0]              line_valid;
   logic [TAG_W-1:0]              line_tag  [LINES];
   logic [31:0]                   line_data [LINES];
   logic [ICACHE_INDEX_WIDTH-1:0] idx;
   logic [TAG_W-1:0]              tag;

   assign idx        = pc[ICACHE_INDEX_WIDTH+1:2];
   assign tag        = pc[31:ICACHE_INDEX_WIDTH+2];
   assign cache_hit  = line_valid[idx] && (line_tag[idx] == tag);
   assign cache_word = line_data[idx];

   // Only reset clears valid bits; flush leaves lines intact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_valid <= '0;
      end else if (bus.rdy && fill) begin
         line_valid[idx] <= 1'b1;
      end
   end

   // pc still holds the miss address while in WAIT_MEM, so idx/tag name the fill line.
   always_ff @(posedge clk) begin
      if (bus.rdy && fill) begin
         line_tag[idx]  <= tag;
         line_data[idx] <= bus.inst_from_mem;
      end
   end
`else
   logic [31:0] cfg_unused;
   assign cfg_unused = ICACHE_INDEX_WIDTH;
   assign cache_hit  = 1'b0;
   assign cache_word = '0;
`endif

   always_comb begin
      state_n  = state;
      pc_n     = pc;
      start_n  = 1'b0;
      pc_mem_n = pc_mem_q;
      valid_n  = 1'b0;
      inst_n   = inst_q;
      pc_q_n   = pc_q;
      fill     = 1'b0;

      if (bus.flush_signal) begin
         // Redirect wins over everything, including a coincident finish pulse.
         pc_n    = bus.flush_target_pc;
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (!bus.queue_full_signal) begin
                  if (cache_hit) begin
                     valid_n = 1'b1;
                     inst_n  = cache_word;
                     pc_q_n  = pc;
                     pc_n    = pc + 32'd4;
                  end else begin
                     start_n  = 1'b1;
                     pc_mem_n = pc;
                     state_n  = WAIT_MEM;
                  end
               end
            end
            WAIT_MEM: begin
               if (bus.finish_query_signal) begin
                  valid_n = 1'b1;
                  inst_n  = bus.inst_from_mem;
                  pc_q_n  = pc;
                  pc_n    = pc + 32'd4;
                  fill    = 1'b1;
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         start_q  <= 1'b0;
         pc_mem_q <= '0;
         valid_q  <= 1'b0;
         inst_q   <= '0;
         pc_q     <= '0;
      end else if (!bus.rdy) begin
         // Frozen: hold state, drop any pulse in flight.
         start_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         start_q  <= start_n;
         pc_mem_q <= pc_mem_n;
         valid_q  <= valid_n;
         inst_q   <= inst_n;
         pc_q     <= pc_q_n;
      end
   end

   assign bus.start_query_signal  = start_q;
   assign bus.pc_to_mem           = pc_mem_q;
   assign bus.inst_valid_to_queue = valid_q;
   assign bus.inst_to_queue       = inst_q;
   assign bus.pc_to_queue         = pc_q;

endmodule

// File: doc/inst_fetcher.md
# inst_fetcher

Instruction fetch stage feeding the memory controller's fetch port and the downstream instruction queue. Holds the architectural fetch PC, issues one-cycle fetch queries, collects returned 32-bit instructions, and forwards each instruction with its PC as a single-cycle valid pulse. On a flush (branch mispredict or exception redirect from commit) it abandons any in-flight fetch and restarts at the supplied target. An optional direct-mapped instruction cache serves hits without a memory round-trip.

## Interface
Parameters:
- ICACHE_INDEX_WIDTH, 6, log2 of cache line count (64 one-word lines); only meaningful with ICACHE_EN
- RESET_PC, 32'h0, fetch PC after reset

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- rdy  input  1  global ready; low freezes all state
- start_query_signal  output  1  one-cycle fetch request pulse to memory controller
- pc_to_mem  output  32  fetch address, valid while start_query_signal high
- finish_query_signal  input  1  one-cycle completion pulse from memory controller
- inst_from_mem  input  32  fetched instruction, valid with finish_query_signal
- flush_signal  input  1  redirect from commit; same wire drives memory controller stop_signal
- flush_target_pc  input  32  new fetch PC, valid with flush_signal
- queue_full_signal  input  1  instruction queue has no free slot
- inst_valid_to_queue  output  1  one-cycle pulse: instruction delivered
- inst_to_queue  output  32  delivered instruction
- pc_to_queue  output  32  PC of delivered instruction

## Operation
- States: IDLE, WAIT_MEM.
- IDLE, flush low, queue_full low:
  - with ICACHE_EN and hit on pc: deliver cached word, pc <= pc+4, stay IDLE.
  - otherwise: pulse start_query_signal with pc_to_mem = pc, go WAIT_MEM.
- IDLE, queue_full high: no query, no delivery, hold.
- WAIT_MEM, finish_query_signal high, flush low: deliver inst_from_mem with pc; with ICACHE_EN write line (valid=1, tag, data); pc <= pc+4; go IDLE.
- WAIT_MEM otherwise: wait; start_query_signal stays low (exactly one pulse per miss).
- Flush (any state, highest priority): pc <= flush_target_pc; state <= IDLE; no delivery that cycle; a finish pulse coincident with flush is discarded and not cached; no query issued in the flush cycle.
- Cache lines are not invalidated by flush; only reset clears valid bits.
- Cache index = pc[ICACHE_INDEX_WIDTH+1:2]; tag = pc[31:ICACHE_INDEX_WIDTH+2]; pc[1:0] always 0, PC arithmetic wraps modulo 2^32.
- rdy low: state, PC, cache frozen; all pulse outputs driven low.

## Timing
- Reset values: start_query_signal 0, pc_to_mem 0, inst_valid_to_queue 0, inst_to_queue 0, pc_to_queue 0; pc = RESET_PC; state IDLE; all cache valid bits 0.
- All outputs registered; pulses high exactly one cycle.
- Miss: start_query_signal rises edge after decision; inst_valid_to_queue rises edge after finish_query_signal is sampled high.
- Hit: inst_valid_to_queue rises edge after IDLE sampling; back-to-back hits sustain one instruction per cycle.
- queue_full_signal sampled only in IDLE before issuing; queue guarantees acceptance of one pulse once issue began with full low.
- Next query after a miss completes: earliest one cycle after delivery.
- After flush: first query (or hit delivery) issued edge after the flush cycle.

## Configuration
- ICACHE_EN defined: direct-mapped cache of 2^ICACHE_INDEX_WIDTH one-word lines, hit path as above, filled on every unflushed miss.
- ICACHE_EN undefined: no cache storage; every fetch goes IDLE -> WAIT_MEM -> IDLE; ICACHE_INDEX_WIDTH ignored.

## Test plan
- Reset, RESET_PC=0, memory returns 32'h00000013 after 6 cycles -> one start_query pulse with pc_to_mem=0, then inst_valid_to_queue pulse with inst 32'h00000013, pc_to_queue 0; next query at pc 4.
- queue_full high in IDLE for 10 cycles -> no start_query pulse; deassert -> query within one cycle.
- Flush to 32'h00001000 while in WAIT_MEM, memctrl finish arrives same cycle -> no delivery, next query pc_to_mem=32'h00001000.
- ICACHE_EN: fetch loop 0..12 twice -> second pass delivers 4 instructions on 4 consecutive cycles with no start_query pulses.
- ICACHE_EN, index 6: fetch 32'h0 then 32'h100 (same index, different tag) then 32'h0 -> third fetch misses and issues query.
- rdy low for 3 cycles mid-WAIT_MEM -> no output pulses, pc unchanged; resumes delivery after rdy returns.
